// File: rtl/hamming_secded_stream_decoder_if.sv
// Streaming port bundle for the SECDED decoder: codeword input, decoded output and error counters.
// The decoder side uses the slave modport; the producer/consumer side uses master.
interface hamming_secded_stream_decoder_if #(
    parameter int DATA_W = 4,
    parameter int CNT_W  = 16
);
    function automatic int calc_par_w(input int dw);
        int r;
        r = 1;
        while ((1 << r) < dw + r + 1) r = r + 1;
        return r;
    endfunction

    localparam int PAR_W = calc_par_w(DATA_W);
    localparam int CW_W  = DATA_W + PAR_W + 1;

    logic              in_valid;
    logic              in_ready;
    logic [CW_W-1:0]   in_cw;
    logic              correct_en;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [1:0]        out_err;
    logic [PAR_W-1:0]  out_syndrome;
    logic              cnt_clr;
    logic [CNT_W-1:0]  cnt_single;
    logic [CNT_W-1:0]  cnt_double;

    modport master (
        output in_valid, in_cw, correct_en, out_ready, cnt_clr,
        input  in_ready, out_valid, out_data, out_err, out_syndrome, cnt_single, cnt_double
    );

    modport slave (
        input  in_valid, in_cw, correct_en, out_ready, cnt_clr,
        output in_ready, out_valid, out_data, out_err, out_syndrome, cnt_single, cnt_double
    );
endinterface

// File: rtl/hamming_secded_stream_decoder.sv
// Two-stage pipelined extended-Hamming (SECDED) decoder with valid/ready flow control
// and saturating single/double error counters.
module hamming_secded_stream_decoder #(
    parameter int DATA_W = 4,
    parameter int CNT_W  = 16
) (
    input  logic clk,
    input  logic rst,
    hamming_secded_stream_decoder_if.slave bus
);
    function automatic int calc_par_w(input int dw);
        int r;
        r = 1;
        while ((1 << r) < dw + r + 1) r = r + 1;
        return r;
    endfunction

    // Codeword position holding data bit j: the j-th non-power-of-two index from 3 upward.
    function automatic int data_pos(input int j);
        int pos;
        int n;
        pos = 2;
        n   = -1;
        while (n < j) begin
            pos = pos + 1;
            if ((pos & (pos - 1)) != 0) n = n + 1;
        end
        return pos;
    endfunction

    localparam int PAR_W = calc_par_w(DATA_W);
    localparam int CW_W  = DATA_W + PAR_W + 1;

    logic              s1_valid_q;
    logic [PAR_W-1:0]  s1_syn_q;
    logic              s1_par_q;
    logic [CW_W-1:0]   s1_cw_q;
    logic              s1_mode_q;
    logic              out_valid_q;
    logic [DATA_W-1:0] out_data_q;
    logic [1:0]        out_err_q;
    logic [PAR_W-1:0]  out_syn_q;
    logic [CNT_W-1:0]  cnt_single_q;
    logic [CNT_W-1:0]  cnt_double_q;

    logic [PAR_W-1:0]  syn_d;
    logic              par_d;
    logic [CW_W-1:0]   cw_fix;
    logic [DATA_W-1:0] data_d;
    logic [1:0]        err_d;
    logic              syn_oor;
    logic              adv2;
    logic              in_ready;
    logic              in_fire;
    logic              out_fire;

    assign adv2     = !out_valid_q || bus.out_ready;
    assign in_ready = !s1_valid_q || adv2;
    assign in_fire  = bus.in_valid && in_ready;
    assign out_fire = out_valid_q && bus.out_ready;

    always_comb begin
        syn_d = '0;
        for (int i = 1; i < CW_W; i++) begin
            if (bus.in_cw[i]) syn_d = syn_d ^ PAR_W'(i);
        end
        par_d = ^bus.in_cw;
    end

    // Syndromes pointing past the last codeword bit cannot be a single error.
    assign syn_oor = 32'(s1_syn_q) > 32'(CW_W - 1);

    always_comb begin
        cw_fix = s1_cw_q;
        err_d  = 2'b00;
        if (syn_oor) begin
            err_d = 2'b10;
        end else if (s1_par_q) begin
            err_d = 2'b01;
            if (s1_mode_q) cw_fix[s1_syn_q] = ~s1_cw_q[s1_syn_q];
        end else if (s1_syn_q != '0) begin
            err_d = 2'b10;
        end
    end

    generate
        for (genvar gi = 0; gi < DATA_W; gi++) begin : g_extract
            localparam int POS = data_pos(gi);
            assign data_d[gi] = cw_fix[POS];
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            s1_syn_q    <= '0;
            s1_par_q    <= 1'b0;
            s1_cw_q     <= '0;
            s1_mode_q   <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_err_q   <= 2'b00;
            out_syn_q   <= '0;
        end else begin
            if (in_ready) s1_valid_q <= bus.in_valid;
            if (in_fire) begin
                s1_syn_q  <= syn_d;
                s1_par_q  <= par_d;
                s1_cw_q   <= bus.in_cw;
                s1_mode_q <= bus.correct_en;
            end
            if (adv2) begin
                out_valid_q <= s1_valid_q;
                if (s1_valid_q) begin
                    out_data_q <= data_d;
                    out_err_q  <= err_d;
                    out_syn_q  <= s1_syn_q;
                end
            end
        end
    end

    // Clear takes priority over an increment in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_single_q <= '0;
            cnt_double_q <= '0;
        end else if (bus.cnt_clr) begin
            cnt_single_q <= '0;
            cnt_double_q <= '0;
        end else if (out_fire) begin
            if (out_err_q == 2'b01 && cnt_single_q != '1) cnt_single_q <= cnt_single_q + 1'b1;
            if (out_err_q == 2'b10 && cnt_double_q != '1) cnt_double_q <= cnt_double_q + 1'b1;
        end
    end

    assign bus.in_ready     = in_ready;
    assign bus.out_valid    = out_valid_q;
    assign bus.out_data     = out_data_q;
    assign bus.out_err      = out_err_q;
    assign bus.out_syndrome = out_syn_q;
    assign bus.cnt_single   = cnt_single_q;
    assign bus.cnt_double   = cnt_double_q;
endmodule

// File: tb/tb_hamming_secded_stream_decoder.sv
// Bench for the SECDED stream decoder at DATA_W=4 (CNT_W=2), 8 and 11: directed vectors,
// exhaustive single/double flips, random multi-flips, random backpressure and mid-stream reset.
module tb_hamming_secded_stream_decoder;
    localparam int NI = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    bit rand_ready = 1'b0;

    logic        drv_valid[NI];
    logic        drv_mode[NI];
    logic        drv_oready[NI];
    logic        drv_clr[NI];
    logic [63:0] drv_cw[NI];
    logic        mon_iready[NI];
    logic        mon_ovalid[NI];
    logic [63:0] mon_data[NI];
    logic [1:0]  mon_err[NI];
    logic [7:0]  mon_syn[NI];
    logic [31:0] mon_cs[NI];
    logic [31:0] mon_cd[NI];

    generate
        for (genvar gi = 0; gi < NI; gi++) begin : g_dut
            localparam int DW = (gi == 0) ? 4 : (gi == 1) ? 8 : 11;
            localparam int PW = (gi == 0) ? 3 : 4;
            localparam int CW = DW + PW + 1;
            localparam int CN = (gi == 0) ? 2 : 16;
            hamming_secded_stream_decoder_if #(.DATA_W(DW), .CNT_W(CN)) bus ();
            hamming_secded_stream_decoder #(.DATA_W(DW), .CNT_W(CN)) dut (
                .clk(clk), .rst(rst), .bus(bus)
            );
            assign bus.in_valid   = drv_valid[gi];
            assign bus.in_cw      = drv_cw[gi][CW-1:0];
            assign bus.correct_en = drv_mode[gi];
            assign bus.out_ready  = drv_oready[gi];
            assign bus.cnt_clr    = drv_clr[gi];
            assign mon_iready[gi] = bus.in_ready;
            assign mon_ovalid[gi] = bus.out_valid;
            assign mon_data[gi]   = 64'(bus.out_data);
            assign mon_err[gi]    = bus.out_err;
            assign mon_syn[gi]    = 8'(bus.out_syndrome);
            assign mon_cs[gi]     = 32'(bus.cnt_single);
            assign mon_cd[gi]     = 32'(bus.cnt_double);
        end
    endgenerate

    // ---------------- reference model ----------------
    function automatic int dw_of(input int i);
        return (i == 0) ? 4 : (i == 1) ? 8 : 11;
    endfunction

    function automatic int cnt_max(input int i);
        return (i == 0) ? 3 : 65535;
    endfunction

    function automatic int par_w(input int dw);
        int r;
        r = 1;
        while ((1 << r) < dw + r + 1) r = r + 1;
        return r;
    endfunction

    function automatic bit is_pow2(input int p);
        return (p & (p - 1)) == 0;
    endfunction

    function automatic logic [63:0] encode(input logic [63:0] d, input int dw);
        logic [63:0] cw;
        int j;
        int s;
        cw = '0;
        j  = 0;
        for (int pos = 3; j < dw; pos++) begin
            if (!is_pow2(pos)) begin
                cw[pos] = d[j];
                j = j + 1;
            end
        end
        s = 0;
        for (int k = 1; k < 64; k++) if (cw[k]) s = s ^ k;
        for (int k = 0; k < par_w(dw); k++) cw[1 << k] = 1'((s >> k) & 1);
        cw[0] = ^cw;
        return cw;
    endfunction

    function automatic logic [63:0] extract(input logic [63:0] cw, input int dw);
        logic [63:0] r;
        int j;
        r = '0;
        j = 0;
        for (int pos = 3; j < dw; pos++) begin
            if (!is_pow2(pos)) begin
                r[j] = cw[pos];
                j = j + 1;
            end
        end
        return r;
    endfunction

    task automatic model_decode(input logic [63:0] cw, input int dw, input logic mode,
                                output logic [63:0] data, output logic [1:0] err,
                                output logic [7:0] syn);
        int cww;
        int s;
        logic p;
        logic [63:0] fixed;
        cww = dw + par_w(dw) + 1;
        s = 0;
        p = 1'b0;
        for (int k = 0; k < cww; k++) begin
            if (cw[k]) begin
                s = s ^ k;
                p = ~p;
            end
        end
        fixed = cw;
        err = 2'd0;
        if (s > cww - 1) err = 2'd2;
        else if (p) begin
            err = 2'd1;
            if (mode) fixed[s] = ~fixed[s];
        end else if (s != 0) err = 2'd2;
        data = extract(fixed, dw);
        syn  = 8'(s);
    endtask

    task automatic chk(input int i, input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s[inst %0d] at %0t: got %0h required %0h", name, i, $time, act, exp);
        end
    endtask

    // ---------------- scoreboard + per-cycle compare ----------------
    logic [63:0] sb_data[NI][512];
    logic [1:0]  sb_err[NI][512];
    logic [7:0]  sb_syn[NI][512];
    int sb_head[NI];
    int sb_tail[NI];
    int m_cs[NI];
    int m_cd[NI];

    always @(negedge clk) begin
        if (rst) begin
            for (int i = 0; i < NI; i++) begin
                sb_head[i] = 0;
                sb_tail[i] = 0;
                m_cs[i] = 0;
                m_cd[i] = 0;
            end
        end else begin
            for (int i = 0; i < NI; i++) begin
                chk(i, "cnt_single", 64'(mon_cs[i]), 64'(m_cs[i]));
                chk(i, "cnt_double", 64'(mon_cd[i]), 64'(m_cd[i]));
                if (mon_ovalid[i]) begin
                    if (sb_head[i] == sb_tail[i]) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL out_valid[inst %0d] at %0t: got 1 required 0 (no word pending)", i, $time);
                    end else begin
                        int idx;
                        idx = sb_head[i] % 512;
                        chk(i, "out_data", mon_data[i], sb_data[i][idx]);
                        chk(i, "out_err", 64'(mon_err[i]), 64'(sb_err[i][idx]));
                        chk(i, "out_syndrome", 64'(mon_syn[i]), 64'(sb_syn[i][idx]));
                        if (drv_oready[i]) begin
                            if (sb_err[i][idx] == 2'd1 && m_cs[i] < cnt_max(i)) m_cs[i]++;
                            if (sb_err[i][idx] == 2'd2 && m_cd[i] < cnt_max(i)) m_cd[i]++;
                            sb_head[i]++;
                        end
                    end
                end
                if (drv_clr[i]) begin
                    m_cs[i] = 0;
                    m_cd[i] = 0;
                end
                if (drv_valid[i] && mon_iready[i]) begin
                    logic [63:0] d;
                    logic [1:0] e;
                    logic [7:0] s;
                    model_decode(drv_cw[i], dw_of(i), drv_mode[i], d, e, s);
                    sb_data[i][sb_tail[i] % 512] = d;
                    sb_err[i][sb_tail[i] % 512]  = e;
                    sb_syn[i][sb_tail[i] % 512]  = s;
                    sb_tail[i]++;
                end
            end
        end
    end

    always @(posedge clk) begin
        #1;
        if (rand_ready) begin
            for (int i = 0; i < NI; i++) begin
                drv_oready[i] = ($urandom_range(0, 3) != 0);
                drv_clr[i]    = ($urandom_range(0, 60) == 0);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int i, input logic [63:0] cw, input logic mode);
        bit hs;
        int budget;
        drv_valid[i] = 1'b1;
        drv_cw[i]    = cw;
        drv_mode[i]  = mode;
        hs = 1'b0;
        budget = 0;
        while (!hs) begin
            @(negedge clk);
            hs = mon_iready[i];
            @(posedge clk);
            #1;
            budget++;
            if (!hs && budget > 200) begin
                n_cmp++;
                n_bad++;
                $display("FAIL in_ready_timeout[inst %0d]: got 0 for 200 cycles required 1", i);
                hs = 1'b1;
            end
        end
        drv_valid[i] = 1'b0;
    endtask

    task automatic send_chk(input int i, input logic [63:0] cw, input logic mode,
                            input logic [63:0] ed, input logic [1:0] ee, input logic [7:0] es);
        send(i, cw, mode);
        step();
        chk(i, "lit_out_valid", 64'(mon_ovalid[i]), 64'd1);
        chk(i, "lit_out_data", mon_data[i], ed);
        chk(i, "lit_out_err", 64'(mon_err[i]), 64'(ee));
        chk(i, "lit_out_syndrome", 64'(mon_syn[i]), 64'(es));
    endtask

    function automatic logic [63:0] rand_data(input int dw);
        logic [63:0] d;
        d = {$urandom, $urandom};
        return d & ((64'd1 << dw) - 64'd1);
    endfunction

    task automatic stream(input int i);
        int dw;
        int cww;
        logic [63:0] cw;
        dw  = dw_of(i);
        cww = dw + par_w(dw) + 1;
        for (int a = 0; a < cww; a++) begin
            cw = encode(rand_data(dw), dw);
            cw[a] = ~cw[a];
            send(i, cw, 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 3) == 0) step();
        end
        for (int a = 0; a < cww; a++) begin
            for (int b = a + 1; b < cww; b++) begin
                cw = encode(rand_data(dw), dw);
                cw[a] = ~cw[a];
                cw[b] = ~cw[b];
                send(i, cw, 1'($urandom_range(0, 1)));
                if ($urandom_range(0, 3) == 0) step();
            end
        end
        for (int n = 0; n < 60; n++) begin
            int nf;
            cw = encode(rand_data(dw), dw);
            nf = $urandom_range(0, 3);
            for (int f = 0; f < nf; f++) begin
                int p;
                p = $urandom_range(0, cww - 1);
                cw[p] = ~cw[p];
            end
            send(i, cw, 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 2) == 0) step();
        end
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [63:0] md;
        logic [1:0] me;
        logic [7:0] ms;
        bit drained;

        for (int i = 0; i < NI; i++) begin
            drv_valid[i] = 1'b0;
            drv_cw[i] = '0;
            drv_mode[i] = 1'b1;
            drv_oready[i] = 1'b1;
            drv_clr[i] = 1'b0;
        end
        step();
        step();
        for (int i = 0; i < NI; i++) begin
            chk(i, "rst_out_valid", 64'(mon_ovalid[i]), 64'd0);
            chk(i, "rst_out_data", mon_data[i], 64'd0);
            chk(i, "rst_out_err", 64'(mon_err[i]), 64'd0);
            chk(i, "rst_cnt_single", 64'(mon_cs[i]), 64'd0);
        end
        step();
        rst = 1'b0;
        #1;
        for (int i = 0; i < NI; i++) chk(i, "post_rst_in_ready", 64'(mon_iready[i]), 64'd1);
        step();

        // Literal pins on the model itself
        chk(0, "model_encode_B", encode(64'hB, 4), 64'hAA);
        model_decode(64'h8A, 4, 1'b0, md, me, ms);
        chk(0, "model_8A_nocorr_data", md, 64'h9);
        chk(0, "model_8A_syndrome", 64'(ms), 64'd5);
        model_decode(64'h1006, 8, 1'b1, md, me, ms);
        chk(1, "model_oor_err", 64'(me), 64'd2);
        chk(1, "model_oor_data", md, 64'h80);

        // Directed vectors, DATA_W=4, CNT_W=2
        send_chk(0, 64'hAA, 1'b1, 64'hB, 2'd0, 8'd0);
        send_chk(0, 64'h8A, 1'b1, 64'hB, 2'd1, 8'd5);
        step();
        chk(0, "lit_cnt_single_1", 64'(mon_cs[0]), 64'd1);
        send_chk(0, 64'h8A, 1'b0, 64'h9, 2'd1, 8'd5);
        send_chk(0, 64'hCA, 1'b1, 64'hD, 2'd2, 8'd3);
        step();
        chk(0, "lit_cnt_double_1", 64'(mon_cd[0]), 64'd1);
        send_chk(0, 64'hAB, 1'b1, 64'hB, 2'd1, 8'd0);
        send_chk(0, 64'h8A, 1'b1, 64'hB, 2'd1, 8'd5);
        send_chk(0, 64'h8A, 1'b1, 64'hB, 2'd1, 8'd5);
        step();
        chk(0, "lit_cnt_single_sat", 64'(mon_cs[0]), 64'd3);
        send_chk(0, 64'h8A, 1'b1, 64'hB, 2'd1, 8'd5);
        drv_clr[0] = 1'b1;
        step();
        drv_clr[0] = 1'b0;
        chk(0, "lit_clr_wins_single", 64'(mon_cs[0]), 64'd0);
        chk(0, "lit_clr_wins_double", 64'(mon_cd[0]), 64'd0);

        // Out-of-range syndrome at DATA_W=8 (flips at 1,2,12 -> s=15)
        send_chk(1, 64'h1006, 1'b1, 64'h80, 2'd2, 8'd15);

        // Back-to-back stream with a 3-cycle downstream stall
        fork
            begin
                send(0, 64'hAA, 1'b1);
                send(0, 64'h8A, 1'b1);
                send(0, 64'hCA, 1'b1);
            end
            begin
                step();
                step();
                drv_oready[0] = 1'b0;
                #1;
                chk(0, "lit_stall_in_ready", 64'(mon_iready[0]), 64'd0);
                step();
                chk(0, "lit_stall_hold_data", mon_data[0], 64'hB);
                chk(0, "lit_stall_hold_valid", 64'(mon_ovalid[0]), 64'd1);
                step();
                step();
                drv_oready[0] = 1'b1;
            end
        join
        repeat (4) step();
        chk(0, "lit_stream_cnt_single", 64'(mon_cs[0]), 64'd1);
        chk(0, "lit_stream_cnt_double", 64'(mon_cd[0]), 64'd1);

        // Randomised and exhaustive-flip traffic on all three widths
        rand_ready = 1'b1;
        fork
            stream(0);
            stream(1);
            stream(2);
        join
        rand_ready = 1'b0;
        for (int i = 0; i < NI; i++) begin
            drv_oready[i] = 1'b1;
            drv_clr[i] = 1'b0;
        end
        drained = 1'b0;
        for (int c = 0; c < 50 && !drained; c++) begin
            step();
            drained = 1'b1;
            for (int i = 0; i < NI; i++) if (sb_head[i] != sb_tail[i]) drained = 1'b0;
        end
        if (!drained) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: words still pending after 50 cycles, required none");
        end
        step();

        // Reset in the middle of a stalled stream
        drv_oready[0] = 1'b0;
        send(0, 64'hAA, 1'b1);
        send(0, 64'h8A, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        for (int i = 0; i < NI; i++) begin
            chk(i, "midrst_out_valid", 64'(mon_ovalid[i]), 64'd0);
            chk(i, "midrst_out_data", mon_data[i], 64'd0);
            chk(i, "midrst_cnt_single", 64'(mon_cs[i]), 64'd0);
        end
        step();
        step();
        rst = 1'b0;
        #1;
        chk(0, "midrst_release_in_ready", 64'(mon_iready[0]), 64'd1);
        chk(0, "midrst_release_out_valid", 64'(mon_ovalid[0]), 64'd0);
        drv_oready[0] = 1'b1;
        step();
        send_chk(0, 64'hAA, 1'b1, 64'hB, 2'd0, 8'd0);
        repeat (3) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog expired");
    end
endmodule
